// File: rtl/dff_share_arbiter_pkg.sv
// Shared types and helpers for the dff_share_arbiter slice.
// Optional assertions in the top are enabled by DFF_SHARE_ARB_ASSERT_EN.
package dff_share_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        LOCKED
    } state_e;

    localparam int unsigned RR_MAX_NREQ = 64;

    // Reference round-robin pick: first set bit at or after ptr, wrapping mod nreq.
    function automatic int unsigned rr_pick(input logic [RR_MAX_NREQ-1:0] req,
                                            input int unsigned             ptr,
                                            input int unsigned             nreq);
        int unsigned win;
        int unsigned idx;
        logic        found;
        win   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < nreq; k++) begin
            idx = (ptr + k) % nreq;
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/dff_share_arbiter_if.sv
// Requester/arbiter bus for the shared flop stage.
interface dff_share_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*DW-1:0] din;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      dout;
    logic               dout_vld;

    modport master (
        output req, lock, din,
        input  gnt, dout, dout_vld
    );

    modport slave (
        input  req, lock, din,
        output gnt, dout, dout_vld
    );
endinterface

// File: rtl/dff_share_arbiter_rr_pick_comb.sv
// Combinational round-robin winner select: rotate by ptr, priority-encode, unrotate.
module rr_pick_comb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [PW-1:0]   o_win,
    output logic            o_any
);
    logic [NREQ-1:0] w_rot;
    int unsigned     w_off;
    logic            w_found;

    // Rotate so ptr lands at bit 0, take lowest set bit, map back mod NREQ.
    always_comb begin
        w_rot   = '0;
        w_off   = 0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_rot[k] = i_req[(32'(i_ptr) + k) % NREQ];
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_off   = k;
                w_found = 1'b1;
            end
        end
        o_win = PW'((32'(i_ptr) + w_off) % NREQ);
        o_any = |i_req;
    end
endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter owning a shared DW-bit registered output stage, with
// bounded locking. Define DFF_SHARE_ARB_ASSERT_EN to compile inline SVA checks.
module dff_share_arbiter
    import dff_share_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_LOCK = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    dff_share_arbiter_if.slave   bus
);
    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned LW = $clog2(MAX_LOCK + 1);

    state_e          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [LW-1:0]   r_lock_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [DW-1:0]   r_dout;
    logic            r_vld;

    logic [PW-1:0]   w_win;
    logic            w_any;
    logic [NREQ-1:0] w_win_oh;
    logic [DW-1:0]   w_win_din;
    logic [DW-1:0]   w_own_din;
    logic [PW-1:0]   w_ptr_nxt;
    logic            w_hold;

    rr_pick_comb #(.NREQ(NREQ), .PW(PW)) u_pick (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_any (w_any)
    );

    // Winner decode, data muxes and the "owner keeps the stage" condition.
    always_comb begin
        w_win_oh        = '0;
        w_win_oh[w_win] = 1'b1;
        w_win_din       = bus.din[w_win*DW +: DW];
        w_own_din       = bus.din[r_owner*DW +: DW];
        w_ptr_nxt       = (32'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
        w_hold          = (r_state == LOCKED) && bus.req[r_owner] && bus.lock[r_owner]
                          && (r_lock_cnt < LW'(MAX_LOCK));
    end

    // FSM, pointer, lock counter and the shared output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_lock_cnt <= '0;
            r_gnt      <= '0;
            r_dout     <= '0;
            r_vld      <= 1'b0;
        end else if (w_hold) begin
            r_dout     <= w_own_din;
            r_vld      <= 1'b1;
            r_lock_cnt <= r_lock_cnt + 1'b1;
        end else if (w_any) begin
            // Normal arbitration; also covers a forced release from LOCKED.
            r_gnt   <= w_win_oh;
            r_dout  <= w_win_din;
            r_vld   <= 1'b1;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_win;
            if (bus.lock[w_win]) begin
                r_state    <= LOCKED;
                r_lock_cnt <= LW'(1);
            end else begin
                r_state    <= GRANT;
                r_lock_cnt <= '0;
            end
        end else begin
            r_gnt      <= '0;
            r_vld      <= 1'b0;
            r_state    <= IDLE;
            r_lock_cnt <= '0;
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.dout     = r_dout;
    assign bus.dout_vld = r_vld;

`ifdef DFF_SHARE_ARB_ASSERT_EN
    logic r_arb;

    // Marks cycles whose grant came from a fresh arbitration (not a lock hold).
    always_ff @(posedge clk) begin
        if (rst) r_arb <= 1'b0;
        else     r_arb <= !w_hold && w_any;
    end

    a_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt));
    a_reset   : assert property (@(posedge clk) rst |=> (r_dout == '0 && r_gnt == '0 && !r_vld));
    a_data    : assert property (@(posedge clk) disable iff (rst)
                    r_vld |-> (r_dout == DW'($past(bus.din) >> (r_owner*DW))));
    a_lockcnt : assert property (@(posedge clk) disable iff (rst) r_lock_cnt <= LW'(MAX_LOCK));

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_fair
        logic [7:0] r_others;
        // Counts arbitrated grants to others while requester gi waits.
        always_ff @(posedge clk) begin
            if (rst || !bus.req[gi] || (r_arb && r_gnt[gi])) r_others <= '0;
            else if (r_arb && r_gnt != '0 && r_others != '1) r_others <= r_others + 1'b1;
        end
        a_fair : assert property (@(posedge clk) disable iff (rst) r_others <= 8'(NREQ - 1));
    end
`endif
endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed self-checking bench for dff_share_arbiter (NREQ=4, DW=8, MAX_LOCK=3).
module tb_dff_share_arbiter;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    dff_share_arbiter_if #(.NREQ(4), .DW(8)) bus ();

    dff_share_arbiter #(.NREQ(4), .DW(8), .MAX_LOCK(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] g, input logic [7:0] d, input logic v);
        check({tag, ".gnt"},  32'(bus.gnt),      32'(g));
        check({tag, ".dout"}, 32'(bus.dout),     32'(d));
        check({tag, ".vld"},  32'(bus.dout_vld), 32'(v));
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.req  = 4'hF;
        bus.lock = 4'h0;
        bus.din  = {8'h13, 8'h12, 8'h11, 8'h10};

        // 1: reset held two edges with all requests up
        step(); chk("rst1", 4'b0000, 8'h00, 1'b0);
        step(); chk("rst2", 4'b0000, 8'h00, 1'b0);

        // 2: plain round robin
        rst = 1'b0;
        step(); chk("rr0", 4'b0001, 8'h10, 1'b1);
        step(); chk("rr1", 4'b0010, 8'h11, 1'b1);
        step(); chk("rr2", 4'b0100, 8'h12, 1'b1);
        step(); chk("rr3", 4'b1000, 8'h13, 1'b1);

        // 3: bounded lock by requester 0, data reloaded while held
        bus.req  = 4'b0101;
        bus.lock = 4'b0001;
        bus.din  = {8'h33, 8'hA2, 8'h31, 8'hA0};
        step(); chk("lk1", 4'b0001, 8'hA0, 1'b1);
        bus.din[7:0] = 8'hB0;
        step(); chk("lk2", 4'b0001, 8'hB0, 1'b1);
        bus.din[7:0] = 8'hC0;
        step(); chk("lk3", 4'b0001, 8'hC0, 1'b1);
        step(); chk("lkrel", 4'b0100, 8'hA2, 1'b1);
        step(); chk("lkagain", 4'b0001, 8'hC0, 1'b1);

        // 4: locked owner drops request mid-lock
        bus.req        = 4'b1000;
        bus.din[31:24] = 8'hD3;
        step(); chk("drop", 4'b1000, 8'hD3, 1'b1);

        // 5: reset while locked with lock_cnt=2, then pointer back at 0
        bus.req      = 4'b0001;
        bus.lock     = 4'b0001;
        bus.din[7:0] = 8'hE0;
        step(); chk("l5a", 4'b0001, 8'hE0, 1'b1);
        step(); chk("l5b", 4'b0001, 8'hE0, 1'b1);
        rst = 1'b1;
        step(); chk("rstlk", 4'b0000, 8'h00, 1'b0);
        rst      = 1'b0;
        bus.req  = 4'hF;
        bus.lock = 4'h0;
        bus.din  = {8'h13, 8'h12, 8'h11, 8'h10};
        step(); chk("postrst", 4'b0001, 8'h10, 1'b1);

        // 6: single request then idle; dout holds
        bus.req = 4'b0010;
        step(); chk("one", 4'b0010, 8'h11, 1'b1);
        bus.req = 4'b0000;
        step(); chk("idle1", 4'b0000, 8'h11, 1'b0);
        step(); chk("idle2", 4'b0000, 8'h11, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
